falafel_req_frontend: RTL and testbench

Multi-client request frontend sitting directly upstream of the falafel allocator top. It accepts alloc/free requests from N_CLIENTS independent requesters and round-robin arbitrates among them. It issues one request at a time on falafel's request handshake, captures falafel's result and routes it back to the originating client. It filters trivial requests (free of NULL, alloc of size 0) locally, without touching the allocator.

---
 rtl/falafel_req_frontend.sv | 135 +++++++++++++
 tb/tb_falafel_req_frontend.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_req_frontend.sv
// Multi-client alloc/free frontend for the falafel allocator.
// Round-robin arbitration, one request in flight, trivial requests answered locally.
module falafel_req_frontend #(
  parameter int N_CLIENTS = 4,
  parameter int DATA_W    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_CLIENTS-1:0]        cl_req_valid_i,
  output logic [N_CLIENTS-1:0]        cl_req_ready_o,
  input  logic [N_CLIENTS-1:0]        cl_req_is_alloc_i,
  input  logic [N_CLIENTS*DATA_W-1:0] cl_req_data_i,
  output logic [N_CLIENTS-1:0]        cl_rsp_valid_o,
  input  logic [N_CLIENTS-1:0]        cl_rsp_ready_i,
  output logic                        cl_rsp_is_write_o,
  output logic [DATA_W-1:0]           cl_rsp_data_o,
  input  logic                        req_alloc_ready_i,
  output logic                        req_alloc_valid_o,
  output logic                        is_alloc_o,
  output logic [DATA_W-1:0]           size_to_allocate_o,
  output logic [DATA_W-1:0]           addr_to_free_o,
  input  logic                        rsp_result_val_i,
  input  logic                        rsp_result_is_write_i,
  input  logic [DATA_W-1:0]           rsp_result_data_i,
  output logic                        result_ready_o
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] RETURN   = 2'd3;

  localparam logic [N_CLIENTS-1:0] ONE = 1;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] scan;
  logic             gnt_any;
  logic             gnt_alloc;
  logic [DATA_W-1:0] gnt_data;
  logic             lat_alloc;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] rsp_data;
  logic             rsp_wr;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] p,
    input int               i
  );
    int s;
    s = int'(p) + i;
    if (s >= N_CLIENTS) s = s - N_CLIENTS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      scan = wrap_add(rr_ptr, i);
      if (!gnt_any && cl_req_valid_i[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  always_comb begin
    gnt_alloc = cl_req_is_alloc_i[gnt_idx];
    gnt_data  = cl_req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Grant is gated by reset so every output is low while rst_ni is held.
  assign cl_req_ready_o = (rst_ni && state == IDLE && gnt_any)
                        ? (ONE << gnt_idx) : '0;
  assign cl_rsp_valid_o = (state == RETURN) ? (ONE << owner) : '0;

  assign req_alloc_valid_o  = (state == ISSUE);
  assign result_ready_o     = (state == WAIT_RSP);
  assign is_alloc_o         = lat_alloc;
  assign size_to_allocate_o = lat_alloc ? lat_data : '0;
  assign addr_to_free_o     = lat_alloc ? '0 : lat_data;
  assign cl_rsp_data_o      = rsp_data;
  assign cl_rsp_is_write_o  = rsp_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lat_alloc <= 1'b0;
      lat_data  <= '0;
      rsp_data  <= '0;
      rsp_wr    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_idx;
            lat_alloc <= gnt_alloc;
            lat_data  <= gnt_data;
            rr_ptr    <= wrap_add(gnt_idx, 1);
            if (gnt_data == '0) begin
              rsp_data <= '0;
              rsp_wr   <= ~gnt_alloc;
              state    <= RETURN;
            end else begin
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (req_alloc_ready_i) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (rsp_result_val_i) begin
            rsp_data <= rsp_result_data_i;
            rsp_wr   <= rsp_result_is_write_i;
            state    <= RETURN;
          end
        end
        RETURN: begin
          if (cl_rsp_ready_i[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_req_frontend.sv
// Directed bench for falafel_req_frontend.
// Expected client responses flow through a scoreboard queue.
module tb_falafel_req_frontend;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam logic [63:0] BASE = 64'h1000_0000;

  typedef struct {
    int          owner;
    logic [63:0] data;
    logic        wr;
  } exp_t;

  logic            clk;
  logic            rst_ni;
  logic [N-1:0]    cl_req_valid_i;
  logic [N-1:0]    cl_req_ready_o;
  logic [N-1:0]    cl_req_is_alloc_i;
  logic [N*DW-1:0] cl_req_data_i;
  logic [N-1:0]    cl_rsp_valid_o;
  logic [N-1:0]    cl_rsp_ready_i;
  logic            cl_rsp_is_write_o;
  logic [DW-1:0]   cl_rsp_data_o;
  logic            req_alloc_ready_i;
  logic            req_alloc_valid_o;
  logic            is_alloc_o;
  logic [DW-1:0]   size_to_allocate_o;
  logic [DW-1:0]   addr_to_free_o;
  logic            rsp_result_val_i;
  logic            rsp_result_is_write_i;
  logic [DW-1:0]   rsp_result_data_i;
  logic            result_ready_o;

  logic            auto_fal;
  logic            auto_cl;
  logic            man_req_ready;
  logic            man_rsp_val;
  logic            man_rsp_wr;
  logic [DW-1:0]   man_rsp_data;
  logic [N-1:0]    man_rsp_ready;

  int   checks;
  int   errors;
  int   cyc;
  int   fal_req_cnt;
  int   res_acc;
  int   base_cnt;
  exp_t sb[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  exp_t mon_e;
  int   mon_g;
  logic [63:0] mon_d;

  falafel_req_frontend #(.N_CLIENTS(N), .DATA_W(DW)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .cl_req_valid_i        (cl_req_valid_i),
    .cl_req_ready_o        (cl_req_ready_o),
    .cl_req_is_alloc_i     (cl_req_is_alloc_i),
    .cl_req_data_i         (cl_req_data_i),
    .cl_rsp_valid_o        (cl_rsp_valid_o),
    .cl_rsp_ready_i        (cl_rsp_ready_i),
    .cl_rsp_is_write_o     (cl_rsp_is_write_o),
    .cl_rsp_data_o         (cl_rsp_data_o),
    .req_alloc_ready_i     (req_alloc_ready_i),
    .req_alloc_valid_o     (req_alloc_valid_o),
    .is_alloc_o            (is_alloc_o),
    .size_to_allocate_o    (size_to_allocate_o),
    .addr_to_free_o        (addr_to_free_o),
    .rsp_result_val_i      (rsp_result_val_i),
    .rsp_result_is_write_i (rsp_result_is_write_i),
    .rsp_result_data_i     (rsp_result_data_i),
    .result_ready_o        (result_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait falafel: always ready, result tied to the issued request.
  always_comb begin
    if (auto_fal) begin
      req_alloc_ready_i     = 1'b1;
      rsp_result_val_i      = 1'b1;
      rsp_result_is_write_i = ~is_alloc_o;
      rsp_result_data_i     = is_alloc_o ? size_to_allocate_o + BASE : '0;
    end else begin
      req_alloc_ready_i     = man_req_ready;
      rsp_result_val_i      = man_rsp_val;
      rsp_result_is_write_i = man_rsp_wr;
      rsp_result_data_i     = man_rsp_data;
    end
    cl_rsp_ready_i = auto_cl ? '1 : man_rsp_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic a, input logic [63:0] d);
    cl_req_is_alloc_i[k] = a;
    cl_req_data_i[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    tick();
    rst_ni = 1'b0;
    cl_req_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    sb.delete();
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  task automatic wait_grants(input int n, input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      mid();
      if (gnt_log.size() >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 64'(gnt_log.size()), 64'(n));
  endtask

  task automatic drain(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      mid();
      if (sb.size() == 0 && cl_rsp_valid_o == '0 && cl_req_ready_o == '0
          && !req_alloc_valid_o && !result_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (req_alloc_valid_o) fal_req_cnt++;
      if (rsp_result_val_i && result_ready_o) res_acc++;
    end
  end

  // Grant monitor: logs grants and, with the auto falafel, predicts responses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && cl_req_ready_o != '0) begin
        chk("gnt_onehot", 64'($onehot(cl_req_ready_o)), 64'(1));
        chk("gnt_valid", 64'(cl_req_ready_o & ~cl_req_valid_i), 64'(0));
        mon_g = 0;
        for (int k = 0; k < N; k++) if (cl_req_ready_o[k]) mon_g = k;
        gnt_log.push_back(mon_g);
        gnt_cyc.push_back(cyc);
        if (auto_fal) begin
          mon_d = cl_req_data_i[mon_g*DW +: DW];
          mon_e.owner = mon_g;
          if (mon_d == 0) begin
            mon_e.data = '0;
            mon_e.wr   = ~cl_req_is_alloc_i[mon_g];
          end else if (cl_req_is_alloc_i[mon_g]) begin
            mon_e.data = mon_d + BASE;
            mon_e.wr   = 1'b0;
          end else begin
            mon_e.data = '0;
            mon_e.wr   = 1'b1;
          end
          sb.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        for (int k = 0; k < N; k++) begin
          if (cl_rsp_valid_o[k] && cl_rsp_ready_i[k]) begin
            if (sb.size() == 0) begin
              chk("rsp_unexpected", 64'(k), 64'(-1));
            end else begin
              mon_e = sb.pop_front();
              chk("rsp_owner", 64'(k), 64'(mon_e.owner));
              chk("rsp_data", cl_rsp_data_o, mon_e.data);
              chk("rsp_wr", 64'(cl_rsp_is_write_o), 64'(mon_e.wr));
            end
          end
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; fal_req_cnt = 0; res_acc = 0;
    rst_ni = 1'b0;
    cl_req_valid_i = 4'hF;
    cl_req_is_alloc_i = '0;
    cl_req_data_i = '0;
    auto_fal = 1'b0; auto_cl = 1'b0;
    man_req_ready = 1'b0; man_rsp_val = 1'b0; man_rsp_wr = 1'b0;
    man_rsp_data = '0; man_rsp_ready = '0;

    // Reset values
    mid();
    chk("rst_req_ready", 64'(cl_req_ready_o), 64'(0));
    chk("rst_req_valid", 64'(req_alloc_valid_o), 64'(0));
    chk("rst_res_ready", 64'(result_ready_o), 64'(0));
    chk("rst_rsp_valid", 64'(cl_rsp_valid_o), 64'(0));
    chk("rst_rsp_data", cl_rsp_data_o, 64'(0));
    chk("rst_size", size_to_allocate_o, 64'(0));
    cl_req_valid_i = '0;
    tick();
    rst_ni = 1'b1;

    // Single alloc from client 2, manual falafel
    tick();
    set_req(2, 1'b1, 64'h40);
    cl_req_valid_i = 4'b0100;
    man_req_ready = 1'b1;
    sb.push_back('{2, 64'h1000, 1'b0});
    mid();
    chk("t1_grant", 64'(cl_req_ready_o), 64'(4'b0100));
    chk("t1_reqv_c0", 64'(req_alloc_valid_o), 64'(0));
    tick();
    cl_req_valid_i = '0;
    set_req(2, 1'b0, 64'h0);
    mid();
    chk("t1_reqv_c1", 64'(req_alloc_valid_o), 64'(1));
    chk("t1_size", size_to_allocate_o, 64'h40);
    chk("t1_addr", addr_to_free_o, 64'h0);
    chk("t1_is_alloc", 64'(is_alloc_o), 64'(1));
    chk("t1_resrdy_c1", 64'(result_ready_o), 64'(0));
    tick();
    man_rsp_val = 1'b1; man_rsp_data = 64'h1000; man_rsp_wr = 1'b0;
    mid();
    chk("t1_resrdy_c2", 64'(result_ready_o), 64'(1));
    chk("t1_rspv_c2", 64'(cl_rsp_valid_o), 64'(0));
    tick();
    man_rsp_val = 1'b0;
    man_rsp_ready = 4'b0100;
    mid();
    chk("t1_rspv_c3", 64'(cl_rsp_valid_o), 64'(4'b0100));
    chk("t1_rsp_data", cl_rsp_data_o, 64'h1000);
    tick();
    man_rsp_ready = '0;
    mid();
    chk("t1_rspv_c4", 64'(cl_rsp_valid_o), 64'(0));

    // Round-robin, all clients valid, zero-wait partners
    do_reset();
    auto_fal = 1'b1; auto_cl = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 64'(32'h100 * (k + 1)));
    tick();
    cl_req_valid_i = 4'b1111;
    wait_grants(5, 60);
    tick();
    cl_req_valid_i = '0;
    drain(40);
    if (gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("rr_all_%0d", i), 64'(gnt_log[i]), 64'(i % N));
      for (int i = 1; i < 5; i++)
        chk($sformatf("rr_gap_%0d", i), 64'(gnt_cyc[i] - gnt_cyc[i-1]),
            64'(4));
    end

    // Round-robin, only clients 1 and 3
    do_reset();
    tick();
    cl_req_valid_i = 4'b1010;
    wait_grants(3, 40);
    tick();
    cl_req_valid_i = '0;
    drain(40);
    if (gnt_log.size() >= 3) begin
      chk("rr13_0", 64'(gnt_log[0]), 64'(1));
      chk("rr13_1", 64'(gnt_log[1]), 64'(3));
      chk("rr13_2", 64'(gnt_log[2]), 64'(1));
    end

    // Trivial filtering: free of NULL, then alloc of size 0
    base_cnt = fal_req_cnt;
    tick();
    set_req(0, 1'b0, 64'h0);
    cl_req_valid_i = 4'b0001;
    mid();
    chk("triv_free_gnt", 64'(cl_req_ready_o), 64'(4'b0001));
    tick();
    cl_req_valid_i = '0;
    mid();
    chk("triv_free_rspv", 64'(cl_rsp_valid_o), 64'(4'b0001));
    chk("triv_free_wr", 64'(cl_rsp_is_write_o), 64'(1));
    chk("triv_free_data", cl_rsp_data_o, 64'h0);
    tick();
    mid();
    tick();
    set_req(0, 1'b1, 64'h0);
    cl_req_valid_i = 4'b0001;
    mid();
    chk("triv_alloc_gnt", 64'(cl_req_ready_o), 64'(4'b0001));
    tick();
    cl_req_valid_i = '0;
    mid();
    chk("triv_alloc_rspv", 64'(cl_rsp_valid_o), 64'(4'b0001));
    chk("triv_alloc_wr", 64'(cl_rsp_is_write_o), 64'(0));
    drain(20);
    chk("triv_no_issue", 64'(fal_req_cnt - base_cnt), 64'(0));

    // Back-pressure on both sides; competing clients must not be granted
    auto_fal = 1'b0; auto_cl = 1'b0;
    man_req_ready = 1'b0; man_rsp_ready = '0;
    gnt_log.delete();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 64'h11);
    set_req(1, 1'b1, 64'hABC0);
    sb.push_back('{1, 64'h7700, 1'b0});
    tick();
    cl_req_valid_i = 4'b1111;
    mid();
    chk("bp_grant", 64'(cl_req_ready_o), 64'(4'b0010));
    tick();
    cl_req_valid_i = 4'b1101;
    set_req(1, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_issue_v", 64'(req_alloc_valid_o), 64'(1));
      chk("bp_issue_size", size_to_allocate_o, 64'hABC0);
      chk("bp_issue_gnt", 64'(cl_req_ready_o), 64'(0));
      tick();
    end
    man_req_ready = 1'b1;
    mid();
    chk("bp_issue_last", 64'(req_alloc_valid_o), 64'(1));
    tick();
    man_req_ready = 1'b0;
    man_rsp_val = 1'b1; man_rsp_data = 64'h7700; man_rsp_wr = 1'b0;
    mid();
    chk("bp_resrdy", 64'(result_ready_o), 64'(1));
    tick();
    man_rsp_val = 1'b0;
    man_rsp_ready = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("bp_ret_v", 64'(cl_rsp_valid_o), 64'(4'b0010));
      chk("bp_ret_data", cl_rsp_data_o, 64'h7700);
      chk("bp_ret_gnt", 64'(cl_req_ready_o), 64'(0));
      tick();
    end
    man_rsp_ready = 4'b0010;
    mid();
    tick();
    cl_req_valid_i = '0;
    man_rsp_ready = '0;
    mid();
    chk("bp_ret_done", 64'(cl_rsp_valid_o), 64'(0));
    chk("bp_grants", 64'(gnt_log.size()), 64'(1));

    // Early result while in ISSUE must wait for WAIT_RSP
    base_cnt = res_acc;
    set_req(3, 1'b1, 64'h20);
    sb.push_back('{3, 64'h5000, 1'b0});
    tick();
    cl_req_valid_i = 4'b1000;
    man_rsp_val = 1'b1; man_rsp_data = 64'h5000; man_rsp_wr = 1'b0;
    mid();
    chk("er_grant", 64'(cl_req_ready_o), 64'(4'b1000));
    chk("er_rr_idle", 64'(result_ready_o), 64'(0));
    tick();
    cl_req_valid_i = '0;
    mid();
    chk("er_rr_iss0", 64'(result_ready_o), 64'(0));
    tick();
    mid();
    chk("er_rr_iss1", 64'(result_ready_o), 64'(0));
    tick();
    man_req_ready = 1'b1;
    mid();
    chk("er_rr_iss2", 64'(result_ready_o), 64'(0));
    tick();
    man_req_ready = 1'b0;
    mid();
    chk("er_rr_wait", 64'(result_ready_o), 64'(1));
    tick();
    man_rsp_ready = 4'b1000;
    mid();
    chk("er_ret_v", 64'(cl_rsp_valid_o), 64'(4'b1000));
    chk("er_rr_ret", 64'(result_ready_o), 64'(0));
    tick();
    man_rsp_ready = '0;
    mid();
    tick();
    man_rsp_val = 1'b0;
    mid();
    chk("er_once", 64'(res_acc - base_cnt), 64'(1));

    // Reset in WAIT_RSP abandons the request
    man_req_ready = 1'b1;
    set_req(2, 1'b1, 64'h30);
    tick();
    cl_req_valid_i = 4'b0100;
    mid();
    chk("mr_grant", 64'(cl_req_ready_o), 64'(4'b0100));
    tick();
    cl_req_valid_i = '0;
    mid();
    tick();
    mid();
    chk("mr_wait", 64'(result_ready_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("mr_res_ready", 64'(result_ready_o), 64'(0));
    chk("mr_req_valid", 64'(req_alloc_valid_o), 64'(0));
    chk("mr_size", size_to_allocate_o, 64'(0));
    chk("mr_rsp_valid", 64'(cl_rsp_valid_o), 64'(0));
    sb.delete();
    gnt_log.delete();
    tick();
    rst_ni = 1'b1;
    auto_fal = 1'b1; auto_cl = 1'b1;
    set_req(0, 1'b1, 64'h200);
    set_req(3, 1'b1, 64'h300);
    cl_req_valid_i = 4'b1001;
    mid();
    chk("mr_prio", 64'(cl_req_ready_o), 64'(4'b0001));
    tick();
    cl_req_valid_i = '0;
    drain(40);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
